// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, or 8E1 when UART_RX_PARITY_EN is defined.
// Mid-bit sampling of a synchronized line, with glitch rejection and break handling.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Parity_Err,
   output logic       o_Frame_Err,
   output logic       o_Rx_Busy
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      PARITY     = 3'd3,
      STOP       = 3'd4,
      CLEANUP    = 3'd5,
      BREAK_WAIT = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      STOP       = 3'd4,
      CLEANUP    = 3'd5,
      BREAK_WAIT = 3'd6
   } state_t;
`endif

   localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);
   localparam logic [9:0] HALF_LAST = 10'((CLKS_PER_BIT - 1) / 2);

   state_t     state_q, state_d;
   logic       rx_meta_q, rx_s_q;
   logic [9:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] data_q, data_d;
   logic [7:0] byte_q, byte_d;
   logic       ferr_q, ferr_d;
   logic       dv_q, dv_d;
   logic       busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic       par_pend_q, par_pend_d;
   logic       perr_q, perr_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      byte_d  = byte_q;
      ferr_d  = ferr_q;
      dv_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_d = par_pend_q;
      perr_d     = perr_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s_q) begin
               state_d = START;
            end
         end
         // A start bit that is high again at its midpoint was only a glitch.
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d         = '0;
               data_d[idx_q] = rx_s_q;
               if (idx_q == 3'd7) begin
                  idx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = '0;
               par_pend_d = rx_s_q ^ (^data_q);
               state_d    = STOP;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
`endif
         // Results are published together so DV is seen in the CLEANUP cycle.
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               dv_d    = 1'b1;
               byte_d  = data_q;
               ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
               perr_d  = par_pend_q;
`endif
               state_d = CLEANUP;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
         end
         CLEANUP: begin
            state_d = ferr_q ? BREAK_WAIT : IDLE;
         end
         BREAK_WAIT: begin
            if (rx_s_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         data_q     <= '0;
         byte_q     <= '0;
         ferr_q     <= 1'b0;
         dv_q       <= 1'b0;
         busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pend_q <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         rx_meta_q  <= i_Rx_Serial;
         rx_s_q     <= rx_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         byte_q     <= byte_d;
         ferr_q     <= ferr_d;
         dv_q       <= dv_d;
         busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_pend_q <= par_pend_d;
         perr_q     <= perr_d;
`endif
      end
   end

   assign o_Rx_DV     = dv_q;
   assign o_Rx_Byte   = byte_q;
   assign o_Frame_Err = ferr_q;
   assign o_Rx_Busy   = busy_q;
`ifdef UART_RX_PARITY_EN
   assign o_Parity_Err = perr_q;
`else
   assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16; follows UART_RX_PARITY_EN if defined.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CPB = 16;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } frame_t;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       o_Rx_DV;
   logic [7:0] o_Rx_Byte;
   logic       o_Parity_Err;
   logic       o_Frame_Err;
   logic       o_Rx_Busy;

   frame_t sb[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     dv_count = 0;
   logic   prev_dv  = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock      (clk),
      .i_Rst_n      (rst_n),
      .i_Rx_Serial  (rx),
      .o_Rx_DV      (o_Rx_DV),
      .o_Rx_Byte    (o_Rx_Byte),
      .o_Parity_Err (o_Parity_Err),
      .o_Frame_Err  (o_Frame_Err),
      .o_Rx_Busy    (o_Rx_Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   // Expected result is queued before the frame goes out on the line.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      frame_t f;
      f.data = b;
`ifdef UART_RX_PARITY_EN
      f.perr = bad_par;
`else
      f.perr = 1'b0;
`endif
      f.ferr = ~stop;
      sb.push_back(f);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      hold_bit((^b) ^ bad_par);
`endif
      hold_bit(stop);
      check("dv_by_stop_end", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      frame_t f;
      if (o_Rx_DV === 1'b1) begin
         dv_count++;
         check("dv_width", prev_dv, 1'b0);
         check("dv_expected", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            f = sb.pop_front();
            check("rx_byte", o_Rx_Byte, f.data);
            check("parity_err", o_Parity_Err, f.perr);
            check("frame_err", o_Frame_Err, f.ferr);
         end
      end
      prev_dv = o_Rx_DV;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      rx    = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_dv", o_Rx_DV, 1'b0);
      check("reset_byte", o_Rx_Byte, 8'h00);
      check("reset_perr", o_Parity_Err, 1'b0);
      check("reset_ferr", o_Frame_Err, 1'b0);
      check("reset_busy", o_Rx_Busy, 1'b0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      $display("[TB] good frame 0xA5");
      send_frame(8'hA5, 1'b0, 1'b1);
      repeat (20) @(negedge clk);

      $display("[TB] frame 0x07 with bad parity bit");
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (20) @(negedge clk);

      $display("[TB] frame 0x3C with low stop bit, line held low");
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      check("break_busy_mid", o_Rx_Busy, 1'b1);
      repeat (20) @(negedge clk);
      check("break_busy_end", o_Rx_Busy, 1'b1);
      rx = 1'b1;
      waited = 0;
      while (o_Rx_Busy && waited < 6) begin
         @(negedge clk);
         waited++;
      end
      check("break_release_busy", o_Rx_Busy, 1'b0);
      check("hold_byte", o_Rx_Byte, 8'h3C);
      check("hold_ferr", o_Frame_Err, 1'b1);
      repeat (20) @(negedge clk);

      $display("[TB] 5-cycle glitch");
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      waited = 0;
      while (o_Rx_Busy && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      repeat (2) @(negedge clk);
      check("glitch_busy", o_Rx_Busy, 1'b0);
      repeat (20) @(negedge clk);

      $display("[TB] reset during data bit 3 of 0xFF");
      hold_bit(1'b0);
      rx = 1'b1;
      repeat (3 * CPB + CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_dv", o_Rx_DV, 1'b0);
      check("midreset_busy", o_Rx_Busy, 1'b0);
      check("midreset_byte", o_Rx_Byte, 8'h00);
      check("midreset_ferr", o_Frame_Err, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      send_frame(8'h12, 1'b0, 1'b1);
      repeat (20) @(negedge clk);

      $display("[TB] back-to-back 0x55, 0xAA");
      send_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'hAA, 1'b0, 1'b1);

      waited = 0;
      while (sb.size() > 0 && waited < 4 * CPB) begin
         @(negedge clk);
         waited++;
      end
      repeat (30) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      check("dv_total", dv_count, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit; legal range 4..1023.
REQ-002 SHALL have port i_Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse marking a completed frame.
REQ-006 SHALL have port o_Rx_Byte  output  8  last received data byte.
REQ-007 SHALL have port o_Parity_Err  output  1  even-parity mismatch flag for the last frame.
REQ-008 SHALL have port o_Frame_Err  output  1  stop-bit-low flag for the last frame.
REQ-009 SHALL have port o_Rx_Busy  output  1  high whenever the FSM is outside IDLE.

Function
REQ-010 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s).
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, CLEANUP, BREAK_WAIT.
REQ-012 IDLE: clock counter and bit index held at 0; rx_s=0 -> START on the next edge.
REQ-013 START: count to (CLKS_PER_BIT-1)/2 (integer divide), then sample: rx_s=0 -> DATA with counter cleared; rx_s=1 -> IDLE with no outputs changed (glitch reject).
REQ-014 DATA: sample rx_s after every CLKS_PER_BIT cycles; store LSB first into bit 0..7; after bit 7 -> PARITY (macro on) or STOP (macro off).
REQ-015 PARITY: sample after CLKS_PER_BIT cycles; flag a parity error when sample != XOR of the 8 data bits (even parity) -> STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; sample=0 sets the frame error -> CLEANUP.
REQ-017 CLEANUP, one cycle: o_Rx_DV=1; o_Rx_Byte, o_Parity_Err and o_Frame_Err update in the same cycle; next state BREAK_WAIT if the frame error is set, else IDLE.
REQ-018 BREAK_WAIT: hold until rx_s=1, then -> IDLE; no new start is detected while the line stays low.
REQ-019 The byte SHALL be delivered even when either error flag is set.
REQ-020 o_Rx_Byte and both error flags SHALL hold their values between DV pulses.
REQ-021 o_Rx_DV SHALL be exactly one cycle wide and never asserted in two consecutive cycles.
REQ-022 Clock counter SHALL be 10 bits wide and must not wrap within a bit period for any legal CLKS_PER_BIT.
REQ-023 Latency: o_Rx_DV SHALL assert exactly one cycle after the stop-bit sample edge.
REQ-024 A new start bit arriving immediately after a good stop bit SHALL be accepted; IDLE is re-entered in the cycle after CLKEANUP.

Reset
REQ-025 Asserting i_Rst_n low SHALL immediately force: state IDLE, counters 0, o_Rx_DV=0, o_Rx_Byte=0, o_Parity_Err=0, o_Frame_Err=0, o_Rx_Busy=0, both synchronizer flops=1.
REQ-026 Reset mid-frame SHALL discard the partial frame with no DV; after release the receiver waits for a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: frame is 8E1 (start, 8 data, even parity, stop); PARITY state present.
REQ-028 Macro UART_RX_PARITY_EN undefined: frame is 8N1; PARITY state omitted; o_Parity_Err tied to 0; DV arrives CLKS_PER_BIT cycles earlier.

Verification (CLKS_PER_BIT=16)
REQ-029 Macro on, send 0xA5 with parity 0 and stop 1 -> one DV pulse; o_Rx_Byte=0xA5; both error flags 0.
REQ-030 Macro on, send 0x07 with parity bit 0 (wrong) -> DV; o_Rx_Byte=0x07; o_Parity_Err=1; o_Frame_Err=0.
REQ-031 Send 0x3C with stop bit 0, then hold the line low for 40 cycles -> DV with o_Frame_Err=1; o_Rx_Busy stays 1 until the line rises; no second DV.
REQ-032 Drive a 5-cycle low glitch -> no DV; o_Rx_Busy returns to 0 within 10 cycles.
REQ-033 Pull i_Rst_n low during data bit 3 of 0xFF, release, then send 0x12 -> exactly one DV, o_Rx_Byte=0x12.
REQ-034 Send 0x55 and 0xAA back-to-back with no idle gap -> two DV pulses carrying 0x55 then 0xAA, no errors.
